// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux4_rr_arbiter
//  Purpose  : Round-robin arbiter owning the select of a shared 4:1 mux.
//             Issues a registered one-hot grant and mux select, presents the
//             granted requester's data and bounds how long any owner can hold
//             the datapath while others are waiting.
//  Revision : 1.0  initial release
// ============================================================================
module mux4_rr_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [3:0]       gnt,
  output logic             sel1,
  output logic             sel0,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  state_t     state_q, state_d;
  logic [3:0] gnt_q,   gnt_d;
  logic [1:0] sel_q,   sel_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [7:0] hold_q,  hold_d;

  logic [3:0] others;
  logic [1:0] pick_all;
  logic [1:0] pick_oth;
  logic       take;
  logic [1:0] win;
  logic [WIDTH-1:0] mux_data;

  // First set bit of mask searching base+1, base+2, base+3, then base itself.
  // Iterating from the farthest offset down lets the nearest match win.
  function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] base);
    logic [1:0] idx;
    rr_pick = base;
    for (int k = 3; k >= 1; k--) begin
      idx = base + 2'(k);
      if (mask[idx]) rr_pick = idx;
    end
  endfunction

  // Candidates other than the current owner; the owner is the set grant bit.
  assign others   = req & ~gnt_q;
  assign pick_all = rr_pick(req, ptr_q);
  assign pick_oth = rr_pick(others, sel_q);

  // Next-state, grant, pointer and hold-counter decisions.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    take    = 1'b0;
    win     = ptr_q;

    unique case (state_q)
      ST_IDLE: begin
        gnt_d = 4'b0000;
        if (|req) begin
          take = 1'b1;
          win  = pick_all;
        end
      end
      ST_GRANT: begin
        if (!req[sel_q]) begin
          // Owner released: hand over directly, or go idle if nobody waits.
          if (|others) begin
            take = 1'b1;
            win  = pick_oth;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            hold_d  = 8'd0;
          end
        end else if (hold_q >= HOLD_LIMIT) begin
          // Hold budget spent: pre-empt if someone else waits, else restart it.
          if (|others) begin
            take = 1'b1;
            win  = pick_oth;
          end else begin
            hold_d = 8'd1;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
      end
    endcase

    if (take) begin
      state_d = ST_GRANT;
      gnt_d   = 4'b0001 << win;
      sel_d   = win;
      ptr_d   = win;
      hold_d  = 8'd1;
    end
  end

  // State register; pointer resets to 3 so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      ptr_q   <= 2'b11;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  // Shared datapath mux, forced to zero when no grant is active.
  always_comb begin
    unique case (sel_q)
      2'd0:    mux_data = in0;
      2'd1:    mux_data = in1;
      2'd2:    mux_data = in2;
      default: mux_data = in3;
    endcase
    out = out_valid ? mux_data : {WIDTH{1'b0}};
  end

  assign gnt       = gnt_q;
  assign sel1      = sel_q[1];
  assign sel0      = sel_q[0];
  assign out_valid = |gnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux4_rr_arbiter
//  Purpose  : Self-checking bench for mux4_rr_arbiter (WIDTH=4, MAX_HOLD=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux4_rr_arbiter;

  localparam int W  = 4;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = 4'b0000;
  logic [W-1:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic [3:0]   gnt;
  logic         sel1, sel0;
  logic [W-1:0] out;
  logic         out_valid;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: current owner (-1 = idle), last winner, cycles held.
  int         m_owner;
  int         m_ptr;
  int         m_held;
  logic [1:0] m_sel;

  typedef struct {
    logic [3:0]   req;
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic [W-1:0] out;
    logic         valid;
  } vec_t;

  vec_t vecs[$];

  mux4_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .gnt       (gnt),
    .sel1      (sel1),
    .sel0      (sel0),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [W-1:0] din(input int s);
    case (s)
      0:       return in0;
      1:       return in1;
      2:       return in2;
      default: return in3;
    endcase
  endfunction

  // Round-robin search: first set bit among base+1 .. base+4 (mod 4).
  function automatic int rr(input logic [3:0] mask, input int base);
    for (int k = 1; k <= 4; k++) begin
      if (mask[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 3;
    m_held  = 0;
    m_sel   = 2'd0;
  endtask

  task automatic model_grant(input int w);
    m_owner = w;
    m_ptr   = w;
    m_sel   = 2'(w);
    m_held  = 1;
  endtask

  // One clock edge of the arbitration rules, given the req seen at that edge.
  task automatic model_update(input logic [3:0] r);
    logic [3:0] oth;
    if (m_owner < 0) begin
      if (r != 0) model_grant(rr(r, m_ptr));
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        if (oth != 0) model_grant(rr(oth, m_owner));
        else m_owner = -1;
      end else if (m_held == MH) begin
        if (oth != 0) model_grant(rr(oth, m_owner));
        else m_held = 1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    chk({tag, ".gnt"},   32'(gnt), 32'(eg));
    chk({tag, ".sel"},   32'({sel1, sel0}), 32'(m_sel));
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_owner >= 0));
    chk({tag, ".out"},   32'(out), (m_owner >= 0) ? 32'(din(m_owner)) : 32'd0);
  endtask

  // Drive req, take one edge, advance the model and compare 1 time unit later.
  task automatic step(input logic [3:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_update(r);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'($urandom_range(0, 15));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.gnt",   32'(gnt), 32'd0);
    chk("rst.sel",   32'({sel1, sel0}), 32'd0);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.out",   32'(out), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                     input logic [W-1:0] o, input logic v);
    vec_t e;
    e.req = r; e.gnt = g; e.sel = s; e.out = o; e.valid = v;
    vecs.push_back(e);
  endtask

  logic [3:0] rr_req [9] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hC, 4'hC, 4'h8, 4'h8, 4'h7};
  logic [3:0] rr_gnt [9] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1};

  initial begin
    // Directed table: single request, idle, sole owner, then two-way pre-emption.
    add(4'b0100, 4'b0100, 2'd2, 4'h1, 1'b1);
    repeat (2)  add(4'b0000, 4'b0000, 2'd2, 4'h0, 1'b0);
    repeat (10) add(4'b1000, 4'b1000, 2'd3, 4'hC, 1'b1);
    add(4'b0000, 4'b0000, 2'd3, 4'h0, 1'b0);
    repeat (4)  add(4'b0011, 4'b0001, 2'd0, 4'hA, 1'b1);
    repeat (4)  add(4'b0011, 4'b0010, 2'd1, 4'h5, 1'b1);
    repeat (4)  add(4'b0011, 4'b0001, 2'd0, 4'hA, 1'b1);
    add(4'b0000, 4'b0000, 2'd0, 4'h0, 1'b0);

    in0 = 4'hA; in1 = 4'h5; in2 = 4'h1; in3 = 4'hC;
    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].req, "tbl");
      chk($sformatf("tbl[%0d].gnt", i),   32'(gnt), 32'(vecs[i].gnt));
      chk($sformatf("tbl[%0d].sel", i),   32'({sel1, sel0}), 32'(vecs[i].sel));
      chk($sformatf("tbl[%0d].out", i),   32'(out), 32'(vecs[i].out));
      chk($sformatf("tbl[%0d].valid", i), 32'(out_valid), 32'(vecs[i].valid));
    end

    // Round-robin hand-over: each owner drops after two cycles, no idle gap.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(rr_req[i], "rr");
      chk($sformatf("rr[%0d].gnt", i), 32'(gnt), 32'(rr_gnt[i]));
    end

    // Reset mid-grant takes effect without a clock edge.
    do_reset();
    step(4'b0100, "mid");
    chk("mid.pre.gnt", 32'(gnt), 32'h4);
    #2;
    rst_n = 1'b0;
    req   = 4'b1111;
    model_reset();
    #1;
    chk("mid.async.gnt",   32'(gnt), 32'd0);
    chk("mid.async.valid", 32'(out_valid), 32'd0);
    chk("mid.async.sel",   32'({sel1, sel0}), 32'd0);
    chk("mid.async.out",   32'(out), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b1111, "mid.rel");
    chk("mid.first.gnt", 32'(gnt), 32'h1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      logic [3:0] r;
      r = req;
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      in0 = W'($urandom); in1 = W'($urandom); in2 = W'($urandom); in3 = W'($urandom);
      step(r, "rnd");
      chk("rnd.onehot", 32'($onehot0(gnt)), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
